// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU, its operation decode and the
// two-requester ALU arbiter.
//   - OP_* localparams : 4-bit ALU operation codes
//   - state_t          : arbiter FSM state encoding
//   - op_supported()   : true for the operation codes the ALU implements
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic op_supported(input logic [3:0] op);
        logic ok;
        case (op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: purely combinational ALU.
//   in1, in2   in  WIDTH  operands
//   operation  in  4      operation code (alu_pkg OP_*)
//   out        out WIDTH  result; 0 for unrecognised codes
//   zero       out 1      result equals zero
// ADD/SUB wrap modulo 2^WIDTH; SLT is a signed compare yielding 1 or 0.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       operation,
    output logic [WIDTH-1:0] out,
    output logic             zero
);

    always_comb begin
        out = '0;
        case (operation)
            OP_AND: out = in1 & in2;
            OP_OR:  out = in1 | in2;
            OP_ADD: out = in1 + in2;
            OP_SUB: out = in1 - in2;
            OP_SLT: out = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            OP_NOR: out = ~(in1 | in2);
            default: out = '0;
        endcase
    end

    assign zero = (out == '0);

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
//   clk, rst                  clock, synchronous active-high reset
//   reqN_valid / reqN_ready   request handshake of requester N (N=0,1)
//   reqN_in1, reqN_in2        operands (WIDTH)
//   reqN_op                   operation code (4)
//   rspN_valid / rspN_ready   response handshake of requester N
//   rspN_out, rspN_zero       result and its zero flag
//   rspN_err                  operation code was unsupported
//   fsm_state                 current FSM state (debug)
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. Requesters hold valid and payload stable until accepted; a
// response stays valid with stable data until the requester takes it.
// ready without a matching valid has no effect.
//
// Flow: IDLE (accept) -> EXEC (ALU, result registered) -> RESP (hold until
// taken) -> IDLE. Accept in cycle T gives rspN_valid in T+2.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int FIRST_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_in1,
    input  logic [WIDTH-1:0] req0_in2,
    input  logic [3:0]       req0_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_out,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_in1,
    input  logic [WIDTH-1:0] req1_in2,
    input  logic [3:0]       req1_op,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_out,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output state_t           fsm_state
);

    state_t           state;
    logic             last_grant;   // requester that completed most recently
    logic             grant_q;      // requester owning the in-flight operation
    logic [WIDTH-1:0] in1_q;
    logic [WIDTH-1:0] in2_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] res_q;
    logic             zero_q;
    logic             err_q;
    logic             rsp_valid_q;

    logic             win;
    logic             any_valid;
    logic             rsp_take;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero;

    alu #(.WIDTH(WIDTH)) u_alu (
        .in1       (in1_q),
        .in2       (in2_q),
        .operation (op_q),
        .out       (alu_out),
        .zero      (alu_zero)
    );

    // Round-robin on contention: the requester not granted last wins.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else if (req1_valid) begin
            win = 1'b1;
        end
    end

    assign any_valid  = req0_valid | req1_valid;
    assign req0_ready = (state == S_IDLE) && req0_valid && !win;
    assign req1_ready = (state == S_IDLE) && req1_valid && win;
    assign rsp_take   = rsp_valid_q && (grant_q ? rsp1_ready : rsp0_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            last_grant  <= (FIRST_PRIO == 0);
            grant_q     <= 1'b0;
            in1_q       <= '0;
            in2_q       <= '0;
            op_q        <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant_q <= win;
                        in1_q   <= win ? req1_in1 : req0_in1;
                        in2_q   <= win ? req1_in2 : req0_in2;
                        op_q    <= win ? req1_op  : req0_op;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    // Unsupported codes report a zero result with err set,
                    // independent of whatever the ALU produces.
                    if (op_supported(op_q)) begin
                        res_q  <= alu_out;
                        zero_q <= alu_zero;
                        err_q  <= 1'b0;
                    end else begin
                        res_q  <= '0;
                        zero_q <= 1'b1;
                        err_q  <= 1'b1;
                    end
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_take) begin
                        rsp_valid_q <= 1'b0;
                        res_q       <= '0;
                        zero_q      <= 1'b0;
                        err_q       <= 1'b0;
                        last_grant  <= grant_q;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response registers are steered to the owner; the other side reads 0.
    assign rsp0_valid = rsp_valid_q && !grant_q;
    assign rsp1_valid = rsp_valid_q && grant_q;
    assign rsp0_out   = rsp0_valid ? res_q : '0;
    assign rsp1_out   = rsp1_valid ? res_q : '0;
    assign rsp0_zero  = rsp0_valid && zero_q;
    assign rsp1_zero  = rsp1_valid && zero_q;
    assign rsp0_err   = rsp0_valid && err_q;
    assign rsp1_err   = rsp1_valid && err_q;
    assign fsm_state  = state;

endmodule
